// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO read side and sends each as an async 8N1 frame on tx
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tx_en        allow new frames (sampled in IDLE)
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO head-of-queue data
//   fifo_pop     one-cycle pop strobe (asserted in LOAD)
//   tx           registered serial line, idle high
//   busy         high from LOAD through the end of STOP
//   tx_done      one-cycle pulse on the last STOP cycle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W);
    typedef enum logic [2:0] {
        IDLE, LOAD, START, DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic tx_q, tx_d, bit_end;
    assign bit_end  = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign fifo_pop = state_q == LOAD;
    assign busy     = state_q != IDLE;
    assign tx_done  = state_q == STOP && bit_end;
    assign tx       = tx_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_en && !fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                cnt_d   = '0;
                idx_d   = '0;
                shreg_d = fifo_data;
                state_d = START;
            end
            START: if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                idx_d = idx_q + IW'(1);
`ifdef UART_TX_PARITY_EN
                if (idx_q == IW'(DATA_W - 1)) state_d = PARITY;
            end
            PARITY: if (bit_end) state_d = STOP;
`else
                if (idx_q == IW'(DATA_W - 1)) state_d = STOP;
            end
`endif
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // tx is driven from the next state so the line changes on the same edge as the FSM
        tx_d = 1'b1;
        if (state_d == START) tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shreg_q[idx_d];
`ifdef UART_TX_PARITY_EN
        else if (state_d == PARITY) tx_d = ^shreg_q;
`endif
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed + random frames checked against a per-cycle waveform model of the UART frame
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 10 + PAR;
    localparam int L  = NB * CPB;

    logic clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0;
    logic fifo_empty, fifo_pop, tx, busy, tx_done;
    logic [7:0] fifo_data;
    logic [7:0] mem [64];
    int wp = 0, rp = 0, pops = 0, bad_pops = 0;
    int checks = 0, failures = 0;

    assign fifo_empty = wp == rp;
    assign fifo_data  = mem[rp[5:0]];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_pop(fifo_pop), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (fifo_pop) begin
        pops <= pops + 1;
        if (fifo_empty) bad_pops <= bad_pops + 1;
        rp <= rp + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp[5:0]] = b;
        wp++;
    endtask

    // Expected tx level per clock of one frame: start 0, data LSB first, optional even parity, stop 1
    function automatic logic [63:0] model_wave(input logic [7:0] b);
        logic [15:0] bits;
        logic [63:0] w;
        bits = '0;
        for (int k = 0; k < 8; k++) bits[k + 1] = b[k];
        if (PAR == 1) bits[9] = ^b;
        bits[NB - 1] = 1'b1;
        w = '0;
        for (int c = 0; c < L; c++) w[c] = bits[c / CPB];
        return w;
    endfunction

    task automatic wait_fall(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 200);
    endtask

    // Called on the negedge where tx was first seen low (frame cycle 0)
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [63:0] obs, dn, bz, all;
        obs = '0; dn = '0; bz = '0; all = '0;
        for (int c = 0; c < L; c++) begin
            if (c > 0) @(negedge clk);
            obs[c] = tx;
            dn[c]  = tx_done;
            bz[c]  = busy;
            all[c] = 1'b1;
        end
        chk({tag, "_wave"}, obs, model_wave(b));
        chk({tag, "_done"}, dn, 64'd1 << (L - 1));
        chk({tag, "_busy"}, bz, all);
    endtask

    initial begin
        int n, bad_tx, bad_busy;
        logic [7:0] rb [6];
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pop", 64'(fifo_pop), 64'd0);
        chk("rst_done", 64'(tx_done), 64'd0);
        rst_n = 1'b1;
        tx_en = 1'b1;
        bad_tx = 0; bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        chk("empty_tx", 64'(bad_tx), 64'd0);
        chk("empty_busy", 64'(bad_busy), 64'd0);
        chk("empty_pops", 64'(pops), 64'd0);

        push(8'h55);
        wait_fall(n);
        chk("single_lat", 64'(n), 64'd2);
        check_frame("single", 8'h55);
        chk("single_pops", 64'(pops), 64'd1);
        chk("single_empty", 64'(fifo_empty), 64'd1);

        @(negedge clk);
        tx_en = 1'b0;
        push(8'h01);
        bad_tx = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
        end
        chk("dis_tx", 64'(bad_tx), 64'd0);
        chk("dis_pops", 64'(pops), 64'd1);
        tx_en = 1'b1;
        wait_fall(n);
        chk("en_lat", 64'(n), 64'd2);
        check_frame("en", 8'h01);

        @(negedge clk);
        push(8'hA5);
        push(8'h3C);
        wait_fall(n);
        check_frame("b2b_a5", 8'hA5);
        wait_fall(n);
        chk("b2b_gap", 64'(n - 1), 64'd2);
        check_frame("b2b_3c", 8'h3C);
        chk("b2b_pops", 64'(pops), 64'd4);

        @(negedge clk);
        push(8'h07);
        push(8'h03);
        wait_fall(n);
        check_frame("par_07", 8'h07);
        wait_fall(n);
        check_frame("par_03", 8'h03);

        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rb[i] = 8'($urandom);
            push(rb[i]);
        end
        for (int i = 0; i < 6; i++) begin
            wait_fall(n);
            if (i > 0) chk("rnd_gap", 64'(n - 1), 64'd2);
            check_frame($sformatf("rnd%0d", i), rb[i]);
        end
        chk("rnd_pops", 64'(pops), 64'd12);

        @(negedge clk);
        push(8'hF0);
        push(8'h42);
        wait_fall(n);
        repeat (17) @(negedge clk);
        chk("mid_tx_low", 64'(tx), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 64'(tx), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(tx_done), 64'd0);
        chk("mid_rst_pop", 64'(fifo_pop), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fall(n);
        chk("after_rst_lat", 64'(n), 64'd2);
        check_frame("after_rst", 8'h42);
        chk("final_pops", 64'(pops), 64'd14);
        chk("pop_when_empty", 64'(bad_pops), 64'd0);
        chk("final_empty", 64'(fifo_empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
